// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: one outstanding bus request feeding an in-order DEPTH-entry buffer.
// Latency: a response is visible at out_* the cycle after it is accepted; a full buffer stalls new requests.
module ifetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          INSTR_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ireq_valid,
    output logic [63:0]              ireq_addr,
    input  logic                     iresp_data_ok,
    input  logic [INSTR_W-1:0]       iresp_data,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [63:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t          state_q;
    logic [63:0]     fetch_pc_q;
    logic [63:0]     ireq_addr_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [63:0]     mem_pc   [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];

    logic            pop;
    logic            push;
    logic [CW-1:0]   count_d;
    logic [63:0]     redir_pc;

    always_comb begin
        pop      = out_valid & out_ready;
        push     = (state_q == S_REQ) & iresp_data_ok & ~redirect_valid;
        count_d  = count_q + CW'(push) - CW'(pop);
        redir_pc = {redirect_pc[63:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            ireq_addr_q <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            // A redirect flushes the buffer and swallows any same-cycle push or pop.
            if (redirect_valid) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                count_q <= count_d;
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        state_q     <= S_REQ;
                        ireq_addr_q <= redir_pc;
                        fetch_pc_q  <= redir_pc;
                    end else if (count_q < DEPTH_C) begin
                        state_q     <= S_REQ;
                        ireq_addr_q <= fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redir_pc;
                        if (iresp_data_ok) begin
                            ireq_addr_q <= redir_pc;
                        end else begin
                            state_q <= S_DROP;
                        end
                    end else if (iresp_data_ok) begin
                        fetch_pc_q <= ireq_addr_q + 64'd4;
                        if (count_d < DEPTH_C) begin
                            ireq_addr_q <= ireq_addr_q + 64'd4;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    // The in-flight response belongs to a stale path; reissue once it lands.
                    if (redirect_valid) begin
                        fetch_pc_q <= redir_pc;
                        if (iresp_data_ok) begin
                            state_q     <= S_REQ;
                            ireq_addr_q <= redir_pc;
                        end
                    end else if (iresp_data_ok) begin
                        state_q     <= S_REQ;
                        ireq_addr_q <= fetch_pc_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_pc[wr_ptr_q]    <= ireq_addr_q;
            mem_instr[wr_ptr_q] <= iresp_data;
        end
    end

    assign ireq_valid = (state_q != S_IDLE);
    assign ireq_addr  = ireq_addr_q;
    assign out_valid  = (count_q != '0);
    assign out_instr  = mem_instr[rd_ptr_q];
    assign out_pc     = mem_pc[rd_ptr_q];
    assign count      = count_q;
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch: expected fetch addresses are queued when a kept response
// is driven and compared when the consumer pops the buffer head.
module tb_ifetch_prefetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  count;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [63:0] sb_q[$];

    ifetch_prefetch dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare any handshake the DUT is about to take, then advance one cycle.
    task automatic tick();
        logic [63:0] e;
        if (reset && !redirect_valid && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexp_out", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_instr", {32'd0, out_instr}, {32'd0, dat(e)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic [63:0] a, input logic [31:0] d, input bit keep);
        chk("req_vld", {63'd0, ireq_valid}, 64'd1);
        chk("req_addr", ireq_addr, a);
        iresp_data_ok = 1'b1;
        iresp_data    = d;
        if (keep) sb_q.push_back(a);
        tick();
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
    endtask

    initial begin
        reset = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_req_vld", {63'd0, ireq_valid}, 64'd0);
        chk("rst_out_vld", {63'd0, out_valid}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_addr", ireq_addr, 64'd0);

        // Back-to-back streaming with a free-running consumer.
        reset = 1'b1; out_ready = 1'b1;
        tick();
        chk("first_addr", ireq_addr, 64'h8000_0000);
        resp(64'h8000_0000, dat(64'h8000_0000), 1'b1);
        chk("lat1_out_vld", {63'd0, out_valid}, 64'd1);
        resp(64'h8000_0004, dat(64'h8000_0004), 1'b1);
        resp(64'h8000_0008, dat(64'h8000_0008), 1'b1);
        tick();
        chk("s1_count", {61'd0, count}, 64'd0);
        chk("s1_addr", ireq_addr, 64'h8000_000C);

        // Fill to DEPTH with a stalled consumer.
        reset = 1'b0; tick(); sb_q.delete(); reset = 1'b1; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            resp(64'h8000_0000 + 64'(4 * i), dat(64'h8000_0000 + 64'(4 * i)), 1'b1);
        end
        chk("full_count", {61'd0, count}, 64'd4);
        chk("full_req_vld", {63'd0, ireq_valid}, 64'd0);
        iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_BAD0;
        tick();
        iresp_data_ok = 1'b0;
        chk("idle_dok_count", {61'd0, count}, 64'd4);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pop_count", {61'd0, count}, 64'd3);
        tick();
        chk("refill_vld", {63'd0, ireq_valid}, 64'd1);
        chk("refill_addr", ireq_addr, 64'h8000_0010);
        out_ready = 1'b1; tick(); tick(); tick();
        chk("drain_count", {61'd0, count}, 64'd0);

        // Redirect with no response pending, stale response arrives later.
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
        tick();
        redirect_valid = 1'b0;
        chk("drop_addr_held", ireq_addr, 64'h8000_0010);
        tick(); tick();
        resp(64'h8000_0010, 32'h0000_DEAD, 1'b0);
        chk("redir_addr", ireq_addr, 64'h8000_1000);
        chk("drop_out_vld", {63'd0, out_valid}, 64'd0);
        resp(64'h8000_1000, dat(64'h8000_1000), 1'b1);
        resp(64'h8000_1004, dat(64'h8000_1004), 1'b1);

        // Redirect coinciding with a response and a pop, buffer holding two.
        out_ready = 1'b0;
        resp(64'h8000_1008, dat(64'h8000_1008), 1'b1);
        chk("pre_flush_cnt", {61'd0, count}, 64'd2);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        resp(64'h8000_100C, dat(64'h8000_100C), 1'b0);
        redirect_valid = 1'b0; sb_q.delete();
        chk("flush_count", {61'd0, count}, 64'd0);
        chk("flush_out_vld", {63'd0, out_valid}, 64'd0);
        resp(64'h8000_2000, dat(64'h8000_2000), 1'b1);
        tick();

        // Two redirects while dropping; only the latest is fetched.
        redirect_valid = 1'b1; redirect_pc = 64'h8000_3000; tick();
        chk("dropA_addr", ireq_addr, 64'h8000_2004);
        redirect_pc = 64'h8000_4000; tick();
        redirect_valid = 1'b0; tick();
        resp(64'h8000_2004, 32'h1111_2222, 1'b0);
        resp(64'h8000_4000, dat(64'h8000_4000), 1'b1);
        tick();

        // Reset during a live request, response arrives while in reset.
        reset = 1'b0; tick();
        iresp_data_ok = 1'b1; iresp_data = 32'h3333_4444; tick();
        iresp_data_ok = 1'b0;
        chk("mid_rst_out_vld", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_count", {61'd0, count}, 64'd0);
        chk("mid_rst_req", {63'd0, ireq_valid}, 64'd0);
        reset = 1'b1; tick();
        chk("restart_addr", ireq_addr, 64'h8000_0000);

        // Address wrap at the top of the 64-bit space.
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFD; tick();
        redirect_valid = 1'b0;
        resp(64'h8000_0000, 32'h5555_6666, 1'b0);
        resp(64'hFFFF_FFFF_FFFF_FFFC, dat(64'hFFFF_FFFF_FFFF_FFFC), 1'b1);
        chk("wrap_addr", ireq_addr, 64'd0);
        resp(64'd0, dat(64'd0), 1'b1);
        tick();
        chk("end_count", {61'd0, count}, 64'd0);
        chk("sb_left", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/ifetch_prefetch.md
IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction-buffer entries (power of 2, >=2).
REQ-002 Parameter RESET_PC, default 64'h8000_0000, SHALL set the first fetch address after reset.
REQ-003 Parameter INSTR_W, default 32, SHALL set the instruction width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be synchronous and active-low: reset==0 at a rising edge resets the block.
REQ-006 ireq_valid  out  1  SHALL signal an outstanding instruction-bus request.
REQ-007 ireq_addr  out  64  SHALL carry the request address, word aligned.
REQ-008 iresp_data_ok  in  1  SHALL complete the outstanding request in the current cycle.
REQ-009 iresp_data  in  INSTR_W  SHALL carry the instruction, valid while iresp_data_ok==1.
REQ-010 redirect_valid  in  1  SHALL request a flush and a refetch from redirect_pc.
REQ-011 redirect_pc  in  64  SHALL carry the new fetch address; bits [1:0] are ignored and treated as 0.
REQ-012 out_valid  out  1  SHALL indicate the buffer head holds an instruction.
REQ-013 out_ready  in  1  SHALL be the consumer's acceptance; pop occurs when out_valid & out_ready.
REQ-014 out_instr / out_pc  out  INSTR_W / 64  SHALL present the head instruction and its address.
REQ-015 count  out  $clog2(DEPTH)+1  SHALL report the number of buffered entries.

Function
REQ-016 The FSM SHALL have states IDLE (no request), REQ (request live, response kept), DROP (request live, response discarded).
REQ-017 ireq_valid SHALL equal (state != IDLE); ireq_addr SHALL be a register held stable from issue until the data_ok cycle, in REQ and in DROP.
REQ-018 In IDLE with count < DEPTH and no redirect, the block SHALL go to REQ with ireq_addr <= fetch_pc.
REQ-019 In REQ with data_ok and no redirect: push {ireq_addr, iresp_data}; fetch_pc <= ireq_addr+4; if count after this cycle's push/pop < DEPTH, stay in REQ with ireq_addr <= ireq_addr+4 (back-to-back, no bubble); else go to IDLE.
REQ-020 A push SHALL never overflow: entry to REQ requires a free slot, and count never rises while a request is live.
REQ-021 A response accepted in cycle t SHALL give out_valid==1 in cycle t+1 when the buffer was empty (1-cycle latency).
REQ-022 The buffer SHALL be in-order; pointers wrap modulo DEPTH; a simultaneous push and pop leaves count unchanged.
REQ-023 out_valid SHALL be (count != 0); out_instr/out_pc SHALL be the head entry; pop with count==0 SHALL have no effect.
REQ-024 redirect_valid SHALL flush: count <= 0, and any same-cycle push or pop is discarded; it has priority over all other events.
REQ-025 Redirect in IDLE: go to REQ with ireq_addr <= redirect_pc.
REQ-026 Redirect in REQ without data_ok: go to DROP, fetch_pc <= redirect_pc.
REQ-027 Redirect in REQ or DROP with data_ok: discard the response, go to REQ with ireq_addr <= redirect_pc.
REQ-028 Redirect in DROP without data_ok: fetch_pc <= redirect_pc, stay in DROP (the latest redirect wins).
REQ-029 In DROP with data_ok and no redirect: discard the response, go to REQ with ireq_addr <= fetch_pc.
REQ-030 ireq_addr and fetch_pc SHALL wrap modulo 2^64.

Reset
REQ-031 At reset: state=IDLE, fetch_pc=RESET_PC, ireq_addr=0, count=0, pointers=0; so ireq_valid=0 and out_valid=0.
REQ-032 Reset mid-request SHALL abandon the request and drop its response; a data_ok seen while in IDLE SHALL be ignored.
REQ-033 The first edge with reset==1 SHALL issue a request with ireq_addr=RESET_PC.

Verification
REQ-034 Release reset; data_ok every cycle; out_ready=1 -> addresses 8000_0000, _0004, _0008 issued back-to-back; out_pc follows in order, 1 cycle later.
REQ-035 out_ready=0; data_ok always; DEPTH=4 -> 4 pushes, count=4, ireq_valid=0; one pop -> the next request issues at 8000_0010.
REQ-036 Redirect to 8000_1002 while in REQ with data_ok=0, then data_ok 3 cycles later with 0xDEAD -> 0xDEAD never output; next ireq_addr=8000_1000.
REQ-037 Redirect in the same cycle as data_ok, with count=2 and out_ready=1 -> count=0, response dropped, ireq_addr=redirect_pc on the next cycle.
REQ-038 Two redirects (A then B) while in DROP, then data_ok -> request issues at B only.
REQ-039 reset=0 asserted while in REQ, then data_ok -> out_valid=0, count=0; after release the fetch restarts at RESET_PC.
